pixelcopy: RTL and testbench

PIXELCOPY -- requirements
Module: pixelcopy

---
 rtl/pixelcopy.sv | 113 +++++++++++
 tb/tb_pixelcopy.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixelcopy.sv
// pixelcopy: copies one RGB565 pixel per accepted address pair (read source, write destination).
// Define PIXELCOPY_DECAY_EN to scale each colour channel by (decay+1)/256 on the way through.
module pixelcopy (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] s_addr,
  input  logic [29:0] d_addr,
  input  logic        pa_ready,
  output logic        pa_next,
  input  logic [7:0]  decay,
  output logic [29:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic [31:0] pix_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]  state_r;
  logic [29:0] src_r;
  logic [29:0] dst_r;
  logic [7:0]  decay_r;
  logic [15:0] pix_s;

`ifdef PIXELCOPY_DECAY_EN
  // Per-channel scale: c * (decay+1) >> 8, products kept within 14 bits.
  function automatic logic [15:0] decay_pix(input logic [15:0] px, input logic [7:0] dc);
    logic [13:0] f;
    logic [13:0] r;
    logic [13:0] g;
    logic [13:0] b;
    f = {6'd0, dc} + 14'd1;
    r = {9'd0, px[15:11]} * f;
    g = {8'd0, px[10:5]} * f;
    b = {9'd0, px[4:0]} * f;
    return {r[12:8], g[13:8], b[12:8]};
  endfunction

  assign pix_s = decay_pix(mem_rdata, decay_r);
`else
  logic unused_decay_s;

  assign pix_s          = mem_rdata;
  assign unused_decay_s = ^decay_r;
`endif

  assign pa_next = (state_r == ST_IDLE);
  assign busy    = ~pa_next;

  // Transfer sequencer: accept pair, read source, write processed pixel to destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      src_r     <= 30'd0;
      dst_r     <= 30'd0;
      decay_r   <= 8'd0;
      mem_addr  <= 30'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 16'd0;
      pix_count <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pa_ready) begin
            src_r    <= s_addr;
            dst_r    <= d_addr;
            decay_r  <= decay;
            mem_addr <= s_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state_r  <= ST_READ;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            mem_wdata <= pix_s;
            mem_addr  <= dst_r;
            mem_we    <= 1'b1;
            state_r   <= ST_WRITE;
          end else begin
            mem_addr  <= src_r;
            state_r   <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            pix_count <= pix_count + 32'd1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_WRITE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixelcopy.sv
// Self-checking bench for pixelcopy: transaction-queue reference model, directed scenarios and random traffic.
module tb_pixelcopy;

  logic        clk;
  logic        rst;
  logic [29:0] s_addr;
  logic [29:0] d_addr;
  logic        pa_ready;
  logic        pa_next;
  logic [7:0]  decay;
  logic [29:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic [31:0] pix_count;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [15:0] data;
  } txn_t;

  // Reference model: pending memory transactions for the current pair.
  txn_t        q[$];
  logic [29:0] m_last_addr;
  logic [29:0] m_dst;
  logic [7:0]  m_decay;
  logic [15:0] m_wdata;
  logic [31:0] m_count;

  pixelcopy dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .d_addr(d_addr), .pa_ready(pa_ready),
    .pa_next(pa_next), .decay(decay), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_pix(input logic [15:0] px, input logic [7:0] dc);
`ifdef PIXELCOPY_DECAY_EN
    int r, g, b, f;
    f = int'(dc) + 1;
    r = (int'(px[15:11]) * f) / 256;
    g = (int'(px[10:5]) * f) / 256;
    b = (int'(px[4:0]) * f) / 256;
    return {r[4:0], g[5:0], b[4:0]};
`else
    return px;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last_addr = 30'd0;
    m_dst       = 30'd0;
    m_decay     = 8'd0;
    m_wdata     = 16'd0;
    m_count     = 32'd0;
  endtask

  task automatic compare();
    logic        idle;
    logic [29:0] ea;
    idle = (q.size() == 0);
    if (!idle) m_last_addr = q[0].addr;
    ea = m_last_addr;
    chk("pa_next", {31'd0, pa_next}, {31'd0, idle});
    chk("busy", {31'd0, busy}, {31'd0, !idle});
    chk("mem_req", {31'd0, mem_req}, {31'd0, !idle});
    chk("mem_we", {31'd0, mem_we}, {31'd0, (!idle && q[0].we)});
    chk("mem_addr", {2'd0, mem_addr}, {2'd0, ea});
    chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
    chk("pix_count", pix_count, m_count);
  endtask

  // One cycle: check outputs, drive inputs for the next edge, advance the model.
  // ack_mode: 0 none, 1 always, 2 follow mem_req, other random.
  task automatic step(input logic pr, input logic [29:0] sa, input logic [29:0] da,
                      input logic [7:0] dc, input int ack_mode, input logic [15:0] rd);
    logic ack;
    txn_t t;
    @(negedge clk);
    compare();
    case (ack_mode)
      0: ack = 1'b0;
      1: ack = 1'b1;
      2: ack = mem_req;
      default: ack = ($urandom_range(0, 99) < 40);
    endcase
    pa_ready  = pr;
    s_addr    = sa;
    d_addr    = da;
    decay     = dc;
    mem_ack   = ack;
    mem_rdata = rd;
    if (q.size() == 0) begin
      if (pr) begin
        q.push_back('{1'b0, sa, 16'h0});
        m_decay = dc;
        m_dst   = da;
      end
    end else if (ack) begin
      t = q.pop_front();
      if (!t.we) begin
        m_wdata = model_pix(rd, m_decay);
        q.push_back('{1'b1, m_dst, m_wdata});
      end else begin
        m_count = m_count + 32'd1;
      end
    end
  endtask

  initial begin
    int n_pa;
    clk = 1'b0; rst = 1'b1;
    s_addr = 30'd0; d_addr = 30'd0; pa_ready = 1'b0; decay = 8'd0;
    mem_rdata = 16'd0; mem_ack = 1'b0;
    model_reset();

    // Literal pins on the model arithmetic.
    chk("model_ffff_255", {16'd0, model_pix(16'hFFFF, 8'd255)}, 32'h0000FFFF);
`ifdef PIXELCOPY_DECAY_EN
    chk("model_f81f_127", {16'd0, model_pix(16'hF81F, 8'd127)}, 32'h0000780F);
    chk("model_decay0", {16'd0, model_pix(16'hFFFF, 8'd0)}, 32'h00000000);
`else
    chk("model_f81f_127", {16'd0, model_pix(16'hF81F, 8'd127)}, 32'h0000F81F);
`endif

    // Reset state.
    @(negedge clk);
    compare();
    chk("rst_pa_next", {31'd0, pa_next}, 32'd1);
    rst = 1'b0;

    // Basic copy, one wait state on each access.
    step(1'b1, 30'h100, 30'h200, 8'd255, 0, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
    chk("d034_rd_addr", {2'd0, mem_addr}, 32'h100);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'hFFFF);
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
    chk("d034_wr_addr", {2'd0, mem_addr}, 32'h200);
    chk("d034_wdata", {16'd0, mem_wdata}, 32'hFFFF);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
    chk("d034_count", pix_count, 32'd1);

    // Decay 127 on magenta.
    step(1'b1, 30'h10, 30'h20, 8'd127, 0, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'hF81F);
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
`ifdef PIXELCOPY_DECAY_EN
    chk("d035_wdata", {16'd0, mem_wdata}, 32'h780F);
`else
    chk("d035_wdata", {16'd0, mem_wdata}, 32'hF81F);
`endif
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);

    // Back-to-back pairs with zero-wait memory.
    n_pa = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 30'($urandom), 30'($urandom), 8'($urandom), 2, 16'($urandom));
      if (pa_next) n_pa++;
    end
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
    chk("d036_pa_count", n_pa, 32'd4);
    chk("d036_count", pix_count, 32'd6);

    // Ack in IDLE ignored, then a 10-cycle read stall.
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);
    step(1'b1, 30'h55, 30'h66, 8'd200, 0, 16'h0);
    chk("d037_idle_pa", {31'd0, pa_next}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
      chk("d037_stall_addr", {2'd0, mem_addr}, 32'h55);
      chk("d037_stall_req", {31'd0, mem_req}, 32'd1);
    end
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h1234);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);

    // Counter wrap from the all-ones value.
    @(negedge clk);
    force dut.pix_count = 32'hFFFF_FFFF;
    #1 release dut.pix_count;
    m_count = 32'hFFFF_FFFF;
    step(1'b1, 30'h7, 30'h8, 8'd255, 0, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'hABCD);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 0, 16'h0);
    chk("d038_wrap", pix_count, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 30'($urandom), 30'($urandom),
           (i % 17 == 0) ? 8'd0 : (i % 13 == 0) ? 8'd255 : 8'($urandom),
           3, 16'($urandom));
    end

    // Reset in the middle of a write.
    step(1'b1, 30'h3, 30'h4, 8'd9, 0, 16'h0);
    step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h5A5A);
    @(negedge clk);
    chk("d033_in_write", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("d033_req", {31'd0, mem_req}, 32'd0);
    chk("d033_pa_next", {31'd0, pa_next}, 32'd1);
    chk("d033_busy", {31'd0, busy}, 32'd0);
    chk("d033_count", pix_count, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 30'h0, 30'h0, 8'd0, 1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
